// File: rtl/serial_sub_ctrl_pkg.sv
// Shared constants for the bit-serial subtraction controller: state encodings
// and the WIDTH legality range.
package serial_sub_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 32;

    function automatic bit width_legal(input int unsigned w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Operand/result handshake bundle for serial_sub_ctrl; master is the requester,
// slave is the controller.
interface serial_sub_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero, busy
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero, busy
    );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: D = A - B - Bin, Bout set when a borrow is needed.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);
    assign D    = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell walked LSB-first over the
// operands, borrow carried in a flop, result registered on entry to DONE.
module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    serial_sub_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             borrow;
    logic [CW-1:0]    count;
    logic             cell_d;
    logic             cell_bout;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             zero_q;

    generate
        if (!width_legal(WIDTH)) begin : g_width_check
            $error("serial_sub_ctrl: WIDTH must lie in 1..32");
        end
    endgenerate

    full_subtractor u_cell (
        .A   (a_sr[0]),
        .B   (b_sr[0]),
        .Bin (borrow),
        .D   (cell_d),
        .Bout(cell_bout)
    );

    // New difference bit enters at the MSB; written as a widened shift so WIDTH=1 works.
    assign res_next = WIDTH'({cell_d, res_sr} >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            borrow <= 1'b0;
            count  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        borrow <= bus.bin;
                        res_sr <= '0;
                        count  <= '0;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    borrow <= cell_bout;
                    count  <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        diff_q <= res_next;
                        bout_q <= cell_bout;
                        zero_q <= (res_next == '0);
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl at WIDTH = 8, 1 and 32 with directed vectors.
module tb_serial_sub_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_sub_ctrl_if #(.WIDTH(8))  ifc8 ();
    serial_sub_ctrl_if #(.WIDTH(1))  ifc1 ();
    serial_sub_ctrl_if #(.WIDTH(32)) ifc32 ();

    serial_sub_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(ifc8.slave));
    serial_sub_ctrl #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(ifc1.slave));
    serial_sub_ctrl #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(ifc32.slave));

    typedef struct packed {
        logic [31:0] diff;
        logic        bout;
        logic        zero;
    } res_t;

    res_t q8[$];
    res_t q1[$];
    res_t q32[$];

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Monitors: a result is consumed whenever the DUT offers it and the consumer accepts.
    always @(negedge clk) begin
        res_t e;
        if (!rst && ifc8.out_valid && ifc8.out_ready) begin
            if (q8.size() == 0) check("w8 unexpected result", 32'd1, 32'd0);
            else begin
                e = q8.pop_front();
                check("w8 diff", {24'b0, ifc8.diff}, e.diff);
                check("w8 bout", {31'b0, ifc8.bout}, {31'b0, e.bout});
                check("w8 zero", {31'b0, ifc8.zero}, {31'b0, e.zero});
            end
        end
    end

    always @(negedge clk) begin
        res_t e;
        if (!rst && ifc1.out_valid && ifc1.out_ready) begin
            if (q1.size() == 0) check("w1 unexpected result", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                check("w1 diff", {31'b0, ifc1.diff}, e.diff);
                check("w1 bout", {31'b0, ifc1.bout}, {31'b0, e.bout});
                check("w1 zero", {31'b0, ifc1.zero}, {31'b0, e.zero});
            end
        end
    end

    always @(negedge clk) begin
        res_t e;
        if (!rst && ifc32.out_valid && ifc32.out_ready) begin
            if (q32.size() == 0) check("w32 unexpected result", 32'd1, 32'd0);
            else begin
                e = q32.pop_front();
                check("w32 diff", ifc32.diff, e.diff);
                check("w32 bout", {31'b0, ifc32.bout}, {31'b0, e.bout});
                check("w32 zero", {31'b0, ifc32.zero}, {31'b0, e.zero});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic bin);
        case (w)
            8:  begin ifc8.in_valid = v;  ifc8.a = a[7:0]; ifc8.b = b[7:0]; ifc8.bin = bin; end
            1:  begin ifc1.in_valid = v;  ifc1.a = a[0];   ifc1.b = b[0];   ifc1.bin = bin; end
            default: begin ifc32.in_valid = v; ifc32.a = a; ifc32.b = b; ifc32.bin = bin; end
        endcase
    endtask

    function automatic logic get_ovalid(input int w);
        case (w)
            8:       return ifc8.out_valid;
            1:       return ifc1.out_valid;
            default: return ifc32.out_valid;
        endcase
    endfunction

    function automatic logic get_iready(input int w);
        case (w)
            8:       return ifc8.in_ready;
            1:       return ifc1.in_ready;
            default: return ifc32.in_ready;
        endcase
    endfunction

    function automatic logic [31:0] get_diff(input int w);
        case (w)
            8:       return {24'b0, ifc8.diff};
            1:       return {31'b0, ifc1.diff};
            default: return ifc32.diff;
        endcase
    endfunction

    // Issue one operation with out_ready high; caller is just after a posedge with the DUT idle.
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic bin,
                          input logic [31:0] ed, input logic eb, input logic ez);
        res_t e;
        int   n;
        e.diff = ed;
        e.bout = eb;
        e.zero = ez;
        case (w)
            8:       q8.push_back(e);
            1:       q1.push_back(e);
            default: q32.push_back(e);
        endcase
        drive(w, 1'b1, a, b, bin);
        step();
        drive(w, 1'b0, '0, '0, 1'b0);
        n = 0;
        @(negedge clk);
        while (!get_ovalid(w) && n < w + 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("w%0d latency", w), n, w);
        step();
        @(negedge clk);
        check($sformatf("w%0d out_valid after accept", w), {31'b0, get_ovalid(w)}, 32'd0);
        check($sformatf("w%0d in_ready after accept", w), {31'b0, get_iready(w)}, 32'd1);
        check($sformatf("w%0d diff held in idle", w), get_diff(w), ed);
        step();
    endtask

    task automatic check_reset8(input string tag);
        check({tag, " in_ready"},  {31'b0, ifc8.in_ready},  32'd1);
        check({tag, " out_valid"}, {31'b0, ifc8.out_valid}, 32'd0);
        check({tag, " busy"},      {31'b0, ifc8.busy},      32'd0);
        check({tag, " diff"},      {24'b0, ifc8.diff},      32'd0);
        check({tag, " bout"},      {31'b0, ifc8.bout},      32'd0);
        check({tag, " zero"},      {31'b0, ifc8.zero},      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        drive(8, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0);
        drive(32, 1'b0, '0, '0, 1'b0);
        ifc8.out_ready  = 1'b1;
        ifc1.out_ready  = 1'b1;
        ifc32.out_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        check_reset8("reset");
        step();
        rst = 1'b0;
        step();

        run_op(8, 32'h5A, 32'h3C, 1'b0, 32'h1E, 1'b0, 1'b0);
        run_op(8, 32'h00, 32'h01, 1'b0, 32'hFF, 1'b1, 1'b0);
        run_op(8, 32'h80, 32'h7F, 1'b1, 32'h00, 1'b0, 1'b1);

        // Back-pressure: result must hold while out_ready is low; in_valid with junk is ignored.
        ifc8.out_ready = 1'b0;
        q8.push_back('{diff: 32'h22, bout: 1'b0, zero: 1'b0});
        drive(8, 1'b1, 32'h33, 32'h11, 1'b0);
        step();
        drive(8, 1'b1, 32'hFF, 32'h00, 1'b1);
        n = 0;
        @(negedge clk);
        while (!ifc8.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("hold latency", n, 8);
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            check("hold out_valid", {31'b0, ifc8.out_valid}, 32'd1);
            check("hold diff",      {24'b0, ifc8.diff},      32'h22);
            check("hold in_ready",  {31'b0, ifc8.in_ready},  32'd0);
        end
        step();
        drive(8, 1'b0, '0, '0, 1'b0);
        ifc8.out_ready = 1'b1;
        step();
        @(negedge clk);
        check("hold release out_valid", {31'b0, ifc8.out_valid}, 32'd0);
        check("hold release in_ready",  {31'b0, ifc8.in_ready},  32'd1);
        step();
        step();
        @(negedge clk);
        check("no stray op busy", {31'b0, ifc8.busy}, 32'd0);
        step();

        // Abort: reset sampled at the edge ending the 4th SHIFT cycle.
        drive(8, 1'b1, 32'h5A, 32'h3C, 1'b0);
        step();
        drive(8, 1'b0, '0, '0, 1'b0);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check_reset8("abort");
        step();
        run_op(8, 32'h10, 32'h01, 1'b0, 32'h0F, 1'b0, 1'b0);

        run_op(1, 32'h0, 32'h1, 1'b0, 32'h1, 1'b1, 1'b0);
        run_op(1, 32'h1, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
        run_op(32, 32'h0, 32'h1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(32, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 32'hCC79_6876, 1'b0, 1'b0);

        step();
        step();
        check("w8 scoreboard drained",  q8.size(),  0);
        check("w1 scoreboard drained",  q1.size(),  0);
        check("w32 scoreboard drained", q32.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
